// File: rtl/rally_score_ctrl.sv
// Rally scoring controller: turns ground/touch faults into points, runs the post-point freeze and game-over hold.
// Optional macro WIN_BY_TWO_EN: win needs >= WIN_SCORE with a 2-point lead, or 31 as a hard cap.
module rally_score_ctrl #(
    parameter logic [11:0] NET_X        = 12'd512,
    parameter logic [4:0]  WIN_SCORE    = 5'd15,
    parameter int          DELAY_CYCLES = 65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gnd_col,
    input  logic        ovr_touch,
    input  logic [11:0] ball_posx,
    input  logic        start,
    output logic [4:0]  score1,
    output logic [4:0]  score2,
    output logic        serve_side,
    output logic        freeze,
    output logic        round_rst,
    output logic        game_over,
    output logic        winner
);

    localparam int          CW        = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CW-1:0] LAST    = CW'(DELAY_CYCLES - 1);
    localparam logic        RR_ON_ENTRY = (DELAY_CYCLES == 1);

    typedef enum logic [1:0] {PLAY, DELAY, GAME_OVER} state_t;

    state_t        r_state;
    logic          r_gnd_d;
    logic          r_ovr_d;
    logic          r_start_d;
    logic [CW-1:0] r_cnt;
    logic [4:0]    r_score1;
    logic [4:0]    r_score2;
    logic          r_serve;
    logic          r_freeze;
    logic          r_round_rst;
    logic          r_game_over;
    logic          r_winner;

    logic          w_event;
    logic          w_start_edge;
    logic          w_p2_scores;
    logic [4:0]    w_scorer_old;
    logic [4:0]    w_scorer_new;
    logic          w_win;

    assign w_event      = (gnd_col & ~r_gnd_d) | (ovr_touch & ~r_ovr_d);
    assign w_start_edge = start & ~r_start_d;
    // Ball on player-1 half means player 1 faulted, so player 2 scores.
    assign w_p2_scores  = (ball_posx < NET_X);
    assign w_scorer_old = w_p2_scores ? r_score2 : r_score1;
    assign w_scorer_new = (w_scorer_old == 5'd31) ? 5'd31 : (w_scorer_old + 5'd1);

`ifdef WIN_BY_TWO_EN
    logic [4:0] w_opp;
    assign w_opp = w_p2_scores ? r_score1 : r_score2;
    assign w_win = ((w_scorer_new >= WIN_SCORE) &&
                    ({1'b0, w_scorer_new} >= ({1'b0, w_opp} + 6'd2))) ||
                   (w_scorer_new == 5'd31);
`else
    assign w_win = (w_scorer_new == WIN_SCORE);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= PLAY;
            r_gnd_d     <= 1'b0;
            r_ovr_d     <= 1'b0;
            r_start_d   <= 1'b0;
            r_cnt       <= '0;
            r_score1    <= 5'd0;
            r_score2    <= 5'd0;
            r_serve     <= 1'b0;
            r_freeze    <= 1'b0;
            r_round_rst <= 1'b0;
            r_game_over <= 1'b0;
            r_winner    <= 1'b0;
        end else begin
            // Edge registers track in every state so a level held through DELAY never fires later.
            r_gnd_d     <= gnd_col;
            r_ovr_d     <= ovr_touch;
            r_start_d   <= start;
            r_round_rst <= 1'b0;
            case (r_state)
                PLAY: begin
                    if (w_event) begin
                        if (w_p2_scores) begin
                            r_score2 <= w_scorer_new;
                            r_serve  <= 1'b1;
                        end else begin
                            r_score1 <= w_scorer_new;
                            r_serve  <= 1'b0;
                        end
                        r_freeze <= 1'b1;
                        if (w_win) begin
                            r_state     <= GAME_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= w_p2_scores;
                        end else begin
                            r_state     <= DELAY;
                            r_cnt       <= '0;
                            r_round_rst <= RR_ON_ENTRY;
                        end
                    end
                end
                DELAY: begin
                    if (r_cnt == LAST) begin
                        r_state  <= PLAY;
                        r_freeze <= 1'b0;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt       <= r_cnt + CW'(1);
                        r_round_rst <= ((r_cnt + CW'(1)) == LAST);
                    end
                end
                GAME_OVER: begin
                    if (w_start_edge) begin
                        r_score1    <= 5'd0;
                        r_score2    <= 5'd0;
                        r_serve     <= ~r_winner;
                        r_game_over <= 1'b0;
                        r_state     <= DELAY;
                        r_cnt       <= '0;
                        r_round_rst <= RR_ON_ENTRY;
                    end
                end
                default: r_state <= PLAY;
            endcase
        end
    end

    assign score1     = r_score1;
    assign score2     = r_score2;
    assign serve_side = r_serve;
    assign freeze     = r_freeze;
    assign round_rst  = r_round_rst;
    assign game_over  = r_game_over;
    assign winner     = r_winner;

endmodule
